// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction game timer: FSM states,
// counter widths and the Galois LFSR step used for the pre-GO delay.
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        GO      = 3'd2,
        DONE    = 3'd3,
        FOUL    = 3'd4,
        TIMEOUT = 3'd5
    } state_t;

    localparam int RESULT_W = 14;
    localparam int DELAY_W  = 12;

    localparam logic [15:0]         LFSR_MASK  = 16'hB400;
    localparam logic [RESULT_W-1:0] BEST_RESET = 14'h3FFF;

    // Right-shifting Galois form: the bit shifted out selects the tap mask.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/reaction_lfsr.sv
// 16-bit Galois LFSR with synchronous reset to SEED and a step enable.
module reaction_lfsr
    import reaction_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] state
);

    logic [15:0] state_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= SEED;
        end else if (en) begin
            state_reg <= lfsr_step(state_reg);
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/reaction_timer.sv
// Reaction game timer: random pre-GO delay, then counts ms ticks until the press.
// Build with REACTION_BEST_TIME_EN defined to track the best (minimum) result.
module reaction_timer
    import reaction_pkg::*;
#(
    parameter int          DELAY_MIN_MS    = 1000,
    parameter int          DELAY_RAND_BITS = 11,
    parameter int          MAX_MS          = 9999,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ms_tick,
    input  logic        start,
    input  logic        btn,
    output logic        go_led,
    output logic        busy,
    output logic [13:0] result_ms,
    output logic        result_valid,
    output logic        foul,
    output logic        timeout,
    output logic [13:0] best_ms
);

    logic start_meta_reg, start_sync_reg, start_prev_reg;
    logic btn_meta_reg, btn_sync_reg, btn_prev_reg;
    logic start_p, btn_p;

    logic [15:0]         lfsr_state;
    logic [DELAY_W-1:0]  delay_val;
    logic                unused_lfsr_bits;

    state_t              state_reg, state_next;
    logic [DELAY_W-1:0]  delay_cnt_reg, delay_cnt_next;
    logic [RESULT_W-1:0] elapsed_reg, elapsed_next;
    logic [RESULT_W-1:0] result_ms_reg, result_ms_next;
    logic                result_valid_reg;
    logic                go_led_reg, busy_reg, foul_reg, timeout_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            start_meta_reg <= 1'b0;
            start_sync_reg <= 1'b0;
            start_prev_reg <= 1'b0;
            btn_meta_reg   <= 1'b0;
            btn_sync_reg   <= 1'b0;
            btn_prev_reg   <= 1'b0;
        end else begin
            start_meta_reg <= start;
            start_sync_reg <= start_meta_reg;
            start_prev_reg <= start_sync_reg;
            btn_meta_reg   <= btn;
            btn_sync_reg   <= btn_meta_reg;
            btn_prev_reg   <= btn_sync_reg;
        end
    end

    assign start_p = start_sync_reg & ~start_prev_reg;
    assign btn_p   = btn_sync_reg & ~btn_prev_reg;

    reaction_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .state (lfsr_state)
    );

    assign delay_val = DELAY_W'(DELAY_MIN_MS) + DELAY_W'(lfsr_state[DELAY_RAND_BITS-1:0]);
    assign unused_lfsr_bits = ^lfsr_state[15:DELAY_RAND_BITS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            delay_cnt_reg    <= '0;
            elapsed_reg      <= '0;
            result_ms_reg    <= '0;
            result_valid_reg <= 1'b0;
            go_led_reg       <= 1'b0;
            busy_reg         <= 1'b0;
            foul_reg         <= 1'b0;
            timeout_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            delay_cnt_reg    <= delay_cnt_next;
            elapsed_reg      <= elapsed_next;
            result_ms_reg    <= result_ms_next;
            // DONE is only reachable from GO, so this is a one-cycle entry pulse.
            result_valid_reg <= (state_next == DONE) && (state_reg == GO);
            go_led_reg       <= (state_next == GO);
            busy_reg         <= (state_next == WAIT) || (state_next == GO);
            foul_reg         <= (state_next == FOUL);
            timeout_reg      <= (state_next == TIMEOUT);
        end
    end

    always_comb begin
        state_next     = state_reg;
        delay_cnt_next = delay_cnt_reg;
        elapsed_next   = elapsed_reg;
        result_ms_next = result_ms_reg;

        case (state_reg)
            IDLE, DONE, FOUL, TIMEOUT: begin
                if (start_p) begin
                    state_next     = WAIT;
                    delay_cnt_next = delay_val;
                    elapsed_next   = '0;
                    result_ms_next = '0;
                end
            end
            WAIT: begin
                // A press beats a final tick landing in the same cycle.
                if (btn_p) begin
                    state_next = FOUL;
                end else if (ms_tick) begin
                    if (delay_cnt_reg <= DELAY_W'(1)) begin
                        state_next   = GO;
                        elapsed_next = '0;
                    end else begin
                        delay_cnt_next = delay_cnt_reg - DELAY_W'(1);
                    end
                end
            end
            GO: begin
                if (btn_p) begin
                    state_next     = DONE;
                    result_ms_next = elapsed_reg;
                end else if (ms_tick) begin
                    if (elapsed_reg == RESULT_W'(MAX_MS - 1)) begin
                        state_next     = TIMEOUT;
                        result_ms_next = RESULT_W'(MAX_MS);
                    end else begin
                        elapsed_next = elapsed_reg + RESULT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign go_led       = go_led_reg;
    assign busy         = busy_reg;
    assign result_ms    = result_ms_reg;
    assign result_valid = result_valid_reg;
    assign foul         = foul_reg;
    assign timeout      = timeout_reg;

`ifdef REACTION_BEST_TIME_EN
    logic [RESULT_W-1:0] best_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            best_reg <= BEST_RESET;
        end else if (result_valid_reg && (result_ms_reg < best_reg)) begin
            best_reg <= result_ms_reg;
        end
    end

    assign best_ms = best_reg;
`else
    assign best_ms = BEST_RESET;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer: a table of rounds plus hand-written
// timeout and reset-during-GO sequences, with a bench-side LFSR model.
module tb_reaction_timer;

`ifdef REACTION_BEST_TIME_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ms_tick = 1'b0;
    logic        start = 1'b0;
    logic        btn = 1'b0;
    logic        go_led, busy, result_valid, foul, timeout;
    logic [13:0] result_ms, best_ms;

    reaction_timer dut (
        .clk          (clk),
        .rst          (rst),
        .ms_tick      (ms_tick),
        .start        (start),
        .btn          (btn),
        .go_led       (go_led),
        .busy         (busy),
        .result_ms    (result_ms),
        .result_valid (result_valid),
        .foul         (foul),
        .timeout      (timeout),
        .best_ms      (best_ms)
    );

    always #5 clk = ~clk;

    // Reference LFSR, stepped on the same edges as the design's.
    logic [15:0] mdl;
    always @(posedge clk) begin
        if (rst) mdl <= 16'hACE1;
        else     mdl <= {1'b0, mdl[15:1]} ^ (mdl[0] ? 16'hB400 : 16'h0000);
    end

    int tests = 0;
    int fails = 0;
    int tick_per = 10;
    int tcnt = 0;
    bit tick_en = 1'b1;
    int rv_cnt = 0;
    int prev_best = 16383;

    typedef struct {
        bit foul_round;
        int press;
        bit coincide;
        int exp_res;
        int exp_best;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Advance to the next negedge, then drive ms_tick for the coming edge.
    task automatic step();
        @(negedge clk);
        if (result_valid === 1'b1) rv_cnt++;
        if (tick_en) begin
            ms_tick = (tcnt == 0);
            tcnt = (tcnt + 1 >= tick_per) ? 0 : tcnt + 1;
        end else begin
            ms_tick = 1'b0;
        end
    endtask

    function automatic int bx(input int v);
        return BEST_EN ? v : 16383;
    endfunction

    task automatic start_round(output int dexp);
        start = 1'b1;
        step();
        step();
        dexp = 1000 + int'(mdl[10:0]);
        step();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_go_led", go_led, 0);
        chk("start_foul_clr", foul, 0);
        chk("start_timeout_clr", timeout, 0);
        chk("start_result_clr", result_ms, 0);
    endtask

    task automatic wait_for_go(input int dexp);
        int n = 0;
        int g = 0;
        while (1) begin
            if (ms_tick) n++;
            step();
            g++;
            if (go_led === 1'b1) break;
            if (g > 40000) begin
                tests++;
                fails++;
                $display("FAIL go_wait_bound: go_led never rose after %0d cycles", g);
                break;
            end
        end
        chk("wait_ticks", n, dexp);
        chk("go_busy", busy, 1);
    endtask

    // Consume n GO ticks, stop ticks, press; optionally land one tick on the accept edge.
    task automatic go_press(input int n, input bit coincide, input int exp_res, input int exp_best);
        int m = 0;
        while (m < n) begin
            if (ms_tick) m++;
            step();
        end
        tick_en = 1'b0;
        ms_tick = 1'b0;
        btn = 1'b1;
        step();
        step();
        if (coincide) ms_tick = 1'b1;
        step();
        chk("done_valid", result_valid, 1);
        chk("done_result", result_ms, exp_res);
        chk("done_go_led", go_led, 0);
        chk("done_busy", busy, 0);
        chk("best_before_update", best_ms, prev_best);
        step();
        chk("done_valid_1cyc", result_valid, 0);
        chk("done_result_hold", result_ms, exp_res);
        chk("best_after_update", best_ms, exp_best);
        btn = 1'b0;
        tick_en = 1'b1;
    endtask

    initial begin
        int dexp;
        int rv0;
        int n;
        int g;

        vecs[0] = '{1'b0, 300, 1'b0, 300, bx(300)};
        vecs[1] = '{1'b0, 180, 1'b0, 180, bx(180)};
        vecs[2] = '{1'b1, 100, 1'b0,   0, bx(180)};
        vecs[3] = '{1'b0, 220, 1'b0, 220, bx(180)};
        vecs[4] = '{1'b0, 250, 1'b0, 250, bx(180)};
        vecs[5] = '{1'b0,  41, 1'b1,  41, bx(41)};
        vecs[6] = '{1'b0,   0, 1'b0,   0, bx(0)};

        rst = 1'b1;
        repeat (3) step();
        chk("rst_go_led", go_led, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result_ms, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_foul", foul, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_best", best_ms, 16383);
        rst = 1'b0;
        repeat (4) step();

        for (int i = 0; i < 7; i++) begin
            tick_per = (i == 0) ? 10 : 1;
            tcnt = 0;
            rv0 = rv_cnt;
            start_round(dexp);
            $display("[TB] round %0d start: expected delay %0d ms", i, dexp);
            if (vecs[i].foul_round) begin
                n = 0;
                while (n < vecs[i].press) begin
                    if (ms_tick) n++;
                    step();
                end
                chk("foul_pre_go_led", go_led, 0);
                tick_en = 1'b0;
                ms_tick = 1'b0;
                btn = 1'b1;
                repeat (3) step();
                chk("foul_level", foul, 1);
                chk("foul_go_led", go_led, 0);
                chk("foul_busy", busy, 0);
                chk("foul_result", result_ms, vecs[i].exp_res);
                btn = 1'b0;
                tick_en = 1'b1;
                repeat (20) step();
                chk("foul_hold", foul, 1);
                chk("foul_no_valid", rv_cnt - rv0, 0);
                chk("foul_best", best_ms, vecs[i].exp_best);
            end else begin
                wait_for_go(dexp);
                if (i > 0) begin
                    tick_per = 2;
                    tcnt = 0;
                end
                go_press(vecs[i].press, vecs[i].coincide, vecs[i].exp_res, vecs[i].exp_best);
                chk("round_valid_count", rv_cnt - rv0, 1);
            end
            prev_best = vecs[i].exp_best;
            $display("[TB] round %0d: result_ms=%0d foul=%0d best_ms=%0d", i, result_ms, foul, best_ms);
            repeat (5) step();
        end

        // Timeout: no press after GO; a later press is ignored.
        tick_per = 1;
        tcnt = 0;
        rv0 = rv_cnt;
        start_round(dexp);
        wait_for_go(dexp);
        n = 0;
        g = 0;
        while (timeout !== 1'b1 && g < 12000) begin
            if (ms_tick) n++;
            step();
            g++;
        end
        chk("timeout_ticks", n, 9999);
        chk("timeout_level", timeout, 1);
        chk("timeout_result", result_ms, 9999);
        chk("timeout_go_led", go_led, 0);
        chk("timeout_busy", busy, 0);
        btn = 1'b1;
        repeat (8) step();
        btn = 1'b0;
        chk("timeout_btn_ignored", timeout, 1);
        chk("timeout_result_hold", result_ms, 9999);
        chk("timeout_no_valid", rv_cnt - rv0, 0);
        chk("timeout_best", best_ms, prev_best);
        $display("[TB] timeout round: result_ms=%0d timeout=%0d", result_ms, timeout);

        // Reset in the middle of GO aborts the round.
        tick_per = 1;
        tcnt = 0;
        rv0 = rv_cnt;
        start_round(dexp);
        wait_for_go(dexp);
        tick_per = 2;
        repeat (20) step();
        rst = 1'b1;
        step();
        chk("rstgo_go_led", go_led, 0);
        chk("rstgo_busy", busy, 0);
        chk("rstgo_result", result_ms, 0);
        chk("rstgo_valid", result_valid, 0);
        chk("rstgo_foul", foul, 0);
        chk("rstgo_timeout", timeout, 0);
        chk("rstgo_best", best_ms, 16383);
        rst = 1'b0;
        repeat (30) step();
        chk("rstgo_idle", busy, 0);
        chk("rstgo_no_valid", rv_cnt - rv0, 0);
        $display("[TB] reset-in-GO: busy=%0d go_led=%0d best_ms=%0d", busy, go_led, best_ms);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Consumer end of the 1 ms tick interface: takes the one-cycle ms_tick strobe and measures the human reaction time in milliseconds.
- On start, waits a pseudo-random delay, lights the GO LED, then counts ms ticks until the player presses the button.
- Reports the result, a foul (press before GO) or a timeout.
- Sits between the ms tick generator and the display/score logic of the reaction game.

Parameters:
- DELAY_MIN_MS, 1000: fixed part of the pre-GO delay, in ms.
- DELAY_RAND_BITS, 11: random part of the delay is an LFSR slice of this width (0..2047 ms).
- MAX_MS, 9999: reaction count limit; reaching it ends the round as a timeout.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk  in  1: system clock, 100 MHz.
- rst  in  1: reset, synchronous, active-high.
- ms_tick  in  1: one-cycle strobe, once per ms.
- start  in  1: debounced start button level, asynchronous to clk.
- btn  in  1: debounced reaction button level, asynchronous to clk.
- go_led  out  1: high while in GO.
- busy  out  1: high in WAIT or GO.
- result_ms  out  14: last reaction time in ms.
- result_valid  out  1: one-cycle pulse on entry to DONE.
- foul  out  1: level, high in FOUL.
- timeout  out  1: level, high in TIMEOUT.
- best_ms  out  14: best (minimum) valid result; see Optional Feature.

Behaviour:
- Reset: one clock and a synchronous active-high reset. While rst is high at a clk edge:
  - state=IDLE.
  - All outputs 0, except best_ms = 14'h3FFF.
  - LFSR = LFSR_SEED; all counters and synchronizers cleared.
- Reset mid-round aborts the round; no result_valid is emitted.
- Input handling:
  - start and btn each pass through a 2-FF synchronizer, then a rising-edge detector.
  - This gives start_p and btn_p, with 3-cycle latency from the pin.
  - Level held high produces exactly one pulse.
- LFSR: 16-bit Galois, mask 16'hB400, advances every clk cycle.
- Delay: delay = DELAY_MIN_MS + lfsr[DELAY_RAND_BITS-1:0], latched in the cycle start_p is accepted. Delay counter is 12 bits wide.
- IDLE:
  - start_p -> WAIT.
  - Load delay_cnt = delay.
  - Clear result_ms, foul and timeout.
- WAIT:
  - On ms_tick, delay_cnt decrements.
  - ms_tick with delay_cnt==1 -> GO: go_led=1 next cycle, elapsed=0. Exactly `delay` ticks are spent in WAIT.
  - btn_p -> FOUL; takes priority over a same-cycle final tick.
  - start_p is ignored.
- GO:
  - On ms_tick, elapsed increments.
  - btn_p -> DONE: result_ms=elapsed, result_valid=1 for one cycle. A tick in the same cycle is not counted.
  - ms_tick with elapsed==MAX_MS-1 (and no btn_p) -> TIMEOUT: result_ms=MAX_MS, timeout=1.
  - start_p is ignored.
- DONE, FOUL, TIMEOUT:
  - Outputs hold.
  - btn_p is ignored.
  - start_p -> WAIT, same actions as from IDLE.
- Simultaneous start_p and btn_p: in IDLE/DONE/FOUL/TIMEOUT start wins. In WAIT/GO btn wins.
- A press with elapsed==0 (before the first tick after GO) is valid: result_ms=0.
- busy = state is WAIT or GO. go_led is registered.

Optional Feature:
- Macro: REACTION_BEST_TIME_EN.
- Defined:
  - On each DONE entry, best_ms <= min(best_ms, result_ms). Updated in the cycle after result_valid.
  - FOUL and TIMEOUT never update best_ms.
  - Only rst restores 14'h3FFF.
- Undefined: best_ms is tied to 14'h3FFF permanently; no compare logic is built.

Decomposition:
- Package reaction_pkg:
  - State enum: IDLE, WAIT, GO, DONE, FOUL, TIMEOUT.
  - RESULT_W=14, DELAY_W=12.
  - LFSR mask 16'hB400.
- Sub-module reaction_lfsr: 16-bit Galois LFSR with SEED parameter, synchronous reset and enable; state output.
- Synchronizer/edge detect stays inline.

Test Plan:
- Bench drives ms_tick every 10 clks. Delay check: start pulse -> GO after exactly `delay` ticks, where delay is computed by a bench LFSR model (seed 16'hACE1). Delay is always within 1000..3047.
- Normal round: press 250 ticks after GO -> result_ms=250, result_valid high for exactly 1 cycle, go_led=0, state DONE.
- Foul: press 100 ticks into WAIT -> foul=1, go_led never rises, result_valid stays 0; a new start clears foul.
- Timeout: no press after GO -> after 9999 ticks, timeout=1 and result_ms=9999; a following press is ignored.
- Edge cases:
  - btn_p coincides with the ms_tick at elapsed=41 -> result_ms=41.
  - Press before the first GO tick -> result_ms=0.
  - rst asserted during GO -> all outputs 0 next cycle.
- REACTION_BEST_TIME_EN: rounds of 300, 180, foul, 220 -> best_ms = 300 then 180, then 180 twice. Without the macro, best_ms=16383 throughout.
